// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: instruction-fetch initiator for the ROM_code memory.
// Owns the PC, sequences the ROM addr/CS strobe, captures the fetched word
// and hands it to decode over valid/ready. Redirects restart fetch at a
// new (word-aligned) PC and discard any fetch in flight.
module rom_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int          STROBE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_VALID  = 2'd3
    } state_t;

    // Counter value on the final CS-high cycle (counter runs 0..STROBE_CYCLES-1).
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [3:0]  strobe_cnt_r;
    logic [3:0]  strobe_cnt_next_s;
    logic        rom_cs_r;
    logic        rom_cs_next_s;
    logic        inst_valid_r;
    logic        inst_valid_next_s;
    logic [31:0] inst_data_r;
    logic [31:0] inst_data_next_s;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_pc_next_s;
    logic        misalign_r;
    logic        misalign_next_s;
    logic [31:0] fetch_count_r;
    logic [31:0] fetch_count_next_s;
    logic        handshake_s;

    assign handshake_s = (state_r == ST_VALID) && inst_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_en) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_next_s = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_cnt_r == STROBE_LAST) begin
                    state_next_s = ST_VALID;
                end else begin
                    state_next_s = ST_STROBE;
                end
            end
            ST_VALID: begin
                if (!inst_ready) begin
                    state_next_s = ST_VALID;
                end else if (fetch_en) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (redirect_valid) begin
            state_next_s = ST_SETUP;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Output/datapath next values: PC, strobe counter, capture, counters.
    always_comb begin
        pc_next_s          = pc_r;
        strobe_cnt_next_s  = 4'd0;
        inst_data_next_s   = inst_data_r;
        inst_pc_next_s     = inst_pc_r;
        fetch_count_next_s = fetch_count_r;
        misalign_next_s    = 1'b0;

        if (handshake_s) begin
            fetch_count_next_s = fetch_count_r + 32'd1;
            pc_next_s          = pc_r + 32'd4;
        end else begin
            fetch_count_next_s = fetch_count_r;
        end

        case (state_r)
            ST_STROBE: begin
                if (strobe_cnt_r == STROBE_LAST) begin
                    inst_data_next_s = rom_data;
                    inst_pc_next_s   = pc_r;
                end else begin
                    strobe_cnt_next_s = strobe_cnt_r + 4'd1;
                end
            end
            default: begin
                strobe_cnt_next_s = 4'd0;
            end
        endcase

        // Redirect wins over pc+4 and throws away any capture this cycle;
        // the handshake count above still stands.
        if (redirect_valid) begin
            pc_next_s         = {redirect_pc[31:2], 2'b00};
            strobe_cnt_next_s = 4'd0;
            inst_data_next_s  = inst_data_r;
            inst_pc_next_s    = inst_pc_r;
            misalign_next_s   = (redirect_pc[1:0] != 2'b00);
        end else begin
            misalign_next_s   = 1'b0;
        end

        rom_cs_next_s     = (state_next_s == ST_STROBE);
        inst_valid_next_s = (state_next_s == ST_VALID);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r          <= RESET_PC;
            strobe_cnt_r  <= 4'd0;
            rom_cs_r      <= 1'b0;
            inst_valid_r  <= 1'b0;
            inst_data_r   <= 32'd0;
            inst_pc_r     <= 32'd0;
            misalign_r    <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            pc_r          <= pc_next_s;
            strobe_cnt_r  <= strobe_cnt_next_s;
            rom_cs_r      <= rom_cs_next_s;
            inst_valid_r  <= inst_valid_next_s;
            inst_data_r   <= inst_data_next_s;
            inst_pc_r     <= inst_pc_next_s;
            misalign_r    <= misalign_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    assign rom_addr     = pc_r;
    assign rom_cs       = rom_cs_r;
    assign inst_valid   = inst_valid_r;
    assign inst_data    = inst_data_r;
    assign inst_pc      = inst_pc_r;
    assign misalign_err = misalign_r;
    assign fetch_count  = fetch_count_r;

endmodule
